// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control.
package pipeline_pkg;

  localparam int REG_AW_DEF = 5;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic id_ex_bubble;
    logic if_id_flush;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline <-> hazard unit bundle: register addresses and events in, selects/stalls out.
interface hazard_forward_unit_if import pipeline_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1_addr_i;
  logic [REG_AW-1:0] id_rs2_addr_i;
  logic [REG_AW-1:0] id_ex_rs1_addr_i;
  logic [REG_AW-1:0] id_ex_rs2_addr_i;
  logic [REG_AW-1:0] id_ex_rd_addr_i;
  logic              id_ex_mem_read_i;
  logic [REG_AW-1:0] ex_mem_rd_addr_i;
  logic              ex_mem_reg_write_i;
  logic [REG_AW-1:0] mem_wb_rd_addr_i;
  logic              mem_wb_reg_write_i;
  logic              div_start_i;
  logic              div_done_i;
  logic              branch_taken_i;
  fwd_sel_t          forward_a_sel_o;
  fwd_sel_t          forward_b_sel_o;
  logic              pc_stall_o;
  logic              if_id_stall_o;
  logic              id_ex_stall_o;
  logic              id_ex_bubble_o;
  logic              if_id_flush_o;
  logic              div_timeout_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  flush_count_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_ex_rs1_addr_i, id_ex_rs2_addr_i,
           id_ex_rd_addr_i, id_ex_mem_read_i, ex_mem_rd_addr_i, ex_mem_reg_write_i,
           mem_wb_rd_addr_i, mem_wb_reg_write_i, div_start_i, div_done_i, branch_taken_i,
    input  forward_a_sel_o, forward_b_sel_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
           id_ex_bubble_o, if_id_flush_o, div_timeout_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_ex_rs1_addr_i, id_ex_rs2_addr_i,
           id_ex_rd_addr_i, id_ex_mem_read_i, ex_mem_rd_addr_i, ex_mem_reg_write_i,
           mem_wb_rd_addr_i, mem_wb_reg_write_i, div_start_i, div_done_i, branch_taken_i,
    output forward_a_sel_o, forward_b_sel_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
           id_ex_bubble_o, if_id_flush_o, div_timeout_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/fwd_select.sv
// Operand forward select for one EX source register; EX/MEM beats MEM/WB, x0 never forwards.
module fwd_select import pipeline_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] ex_mem_rd_addr,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd_addr,
  input  logic              mem_wb_reg_write,
  output fwd_sel_t          sel
);
  logic ex_hit, wb_hit;

  assign ex_hit = ex_mem_reg_write && (ex_mem_rd_addr != '0) && (ex_mem_rd_addr == rs_addr);
  assign wb_hit = mem_wb_reg_write && (mem_wb_rd_addr != '0) && (mem_wb_rd_addr == rs_addr);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit)      sel = FWD_EXMEM;
    else if (wb_hit) sel = FWD_MEMWB;
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage control: operand forwarding, load-use / divide stalls, branch flush,
// divide watchdog and saturating stall/flush counters.
module hazard_forward_unit import pipeline_pkg::*; #(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  hazard_forward_unit_if.slave bus
);
  localparam int NUM_OPS = 2;
  localparam int WD_W    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

  logic [NUM_OPS-1:0][REG_AW-1:0] op_rs;
  fwd_sel_t [NUM_OPS-1:0]         op_sel;

  assign op_rs = {bus.id_ex_rs2_addr_i, bus.id_ex_rs1_addr_i};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .rs_addr          (op_rs[g]),
      .ex_mem_rd_addr   (bus.ex_mem_rd_addr_i),
      .ex_mem_reg_write (bus.ex_mem_reg_write_i),
      .mem_wb_rd_addr   (bus.mem_wb_rd_addr_i),
      .mem_wb_reg_write (bus.mem_wb_reg_write_i),
      .sel              (op_sel[g])
    );
  end

  assign bus.forward_a_sel_o = rst ? FWD_RF : op_sel[0];
  assign bus.forward_b_sel_o = rst ? FWD_RF : op_sel[1];

  hz_state_e        state;
  logic [WD_W-1:0]  wdog;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use, div_stall;
  hz_ctrl_t         ctrl;

  assign load_use = (state == RUN) && bus.id_ex_mem_read_i && (bus.id_ex_rd_addr_i != '0) &&
                    ((bus.id_ex_rd_addr_i == bus.id_rs1_addr_i) ||
                     (bus.id_ex_rd_addr_i == bus.id_rs2_addr_i));
  assign div_stall = (state == DIV_WAIT) && !bus.div_done_i;

  // A taken branch must fetch its target, so it cancels any hold on PC and IF/ID.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      if (load_use) begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
      end
      if (div_stall) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.id_ex_stall = 1'b1;
      end
      if (bus.branch_taken_i) begin
        ctrl.pc_stall     = 1'b0;
        ctrl.if_id_stall  = 1'b0;
        ctrl.id_ex_stall  = 1'b0;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wdog      <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.div_start_i && !bus.div_done_i) begin
            state <= DIV_WAIT;
            wdog  <= '0;
          end
        end
        DIV_WAIT: begin
          if (bus.div_done_i) begin
            state <= RUN;
          end else if (wdog == WD_LAST) begin
            timeout <= 1'b1;
            state   <= RUN;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: state <= RUN;
      endcase
      if (ctrl.pc_stall && !(&stall_cnt))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl.if_id_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_stall_o     = ctrl.pc_stall;
  assign bus.if_id_stall_o  = ctrl.if_id_stall;
  assign bus.id_ex_stall_o  = ctrl.id_ex_stall;
  assign bus.id_ex_bubble_o = ctrl.id_ex_bubble;
  assign bus.if_id_flush_o  = ctrl.if_id_flush;
  assign bus.div_timeout_o  = timeout;
  assign bus.stall_cycles_o = stall_cnt;
  assign bus.flush_count_o  = flush_cnt;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: combinational vector table plus multi-cycle divide/branch/watchdog/reset sequences.
module tb_hazard_forward_unit;
  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ide_rs1, ide_rs2, ide_rd, exm_rd, mwb_rd;
  logic mem_read, exm_wr, mwb_wr, div_start, div_done, branch;
  int n_chk = 0, n_fail = 0;

  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(32)) ifc ();
  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(32)) ifc_wd ();

  hazard_forward_unit #(.REG_AW(5), .CNT_W(32), .DIV_TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .bus(ifc.slave));
  hazard_forward_unit #(.REG_AW(5), .CNT_W(32), .DIV_TIMEOUT(8)) u_dut_wd (
    .clk(clk), .rst(rst), .bus(ifc_wd.slave));

  assign ifc.id_rs1_addr_i = id_rs1;       assign ifc_wd.id_rs1_addr_i = id_rs1;
  assign ifc.id_rs2_addr_i = id_rs2;       assign ifc_wd.id_rs2_addr_i = id_rs2;
  assign ifc.id_ex_rs1_addr_i = ide_rs1;   assign ifc_wd.id_ex_rs1_addr_i = ide_rs1;
  assign ifc.id_ex_rs2_addr_i = ide_rs2;   assign ifc_wd.id_ex_rs2_addr_i = ide_rs2;
  assign ifc.id_ex_rd_addr_i = ide_rd;     assign ifc_wd.id_ex_rd_addr_i = ide_rd;
  assign ifc.id_ex_mem_read_i = mem_read;  assign ifc_wd.id_ex_mem_read_i = mem_read;
  assign ifc.ex_mem_rd_addr_i = exm_rd;    assign ifc_wd.ex_mem_rd_addr_i = exm_rd;
  assign ifc.ex_mem_reg_write_i = exm_wr;  assign ifc_wd.ex_mem_reg_write_i = exm_wr;
  assign ifc.mem_wb_rd_addr_i = mwb_rd;    assign ifc_wd.mem_wb_rd_addr_i = mwb_rd;
  assign ifc.mem_wb_reg_write_i = mwb_wr;  assign ifc_wd.mem_wb_reg_write_i = mwb_wr;
  assign ifc.div_start_i = div_start;      assign ifc_wd.div_start_i = div_start;
  assign ifc.div_done_i = div_done;        assign ifc_wd.div_done_i = div_done;
  assign ifc.branch_taken_i = branch;      assign ifc_wd.branch_taken_i = branch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ide_rs1, ide_rs2, ide_rd;
    logic       mem_read;
    logic [4:0] exm_rd;
    logic       exm_wr;
    logic [4:0] mwb_rd;
    logic       mwb_wr, branch;
    logic [1:0] fa, fb;
    logic       pcs, ifs, bub, fl;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ide_rs1, ide_rs2, ide_rd, exm_rd, mwb_rd} = '0;
    {mem_read, exm_wr, mwb_wr, div_start, div_done, branch} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk); #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  int n;

  initial begin
    //           id1 id2 e1  e2  erd mr exrd exw wbrd wbw br  fa     fb     pcs ifs bub fl
    vecs[0]  = '{0,  0,  5,  0,  0,  0, 5,   1,  5,   1,  0,  2'b01, 2'b00, 0,  0,  0,  0};
    vecs[1]  = '{0,  0,  5,  0,  0,  0, 5,   0,  5,   1,  0,  2'b10, 2'b00, 0,  0,  0,  0};
    vecs[2]  = '{0,  0,  0,  0,  0,  0, 0,   1,  0,   1,  0,  2'b00, 2'b00, 0,  0,  0,  0};
    vecs[3]  = '{0,  0,  9,  7,  0,  0, 7,   1,  9,   1,  0,  2'b10, 2'b01, 0,  0,  0,  0};
    vecs[4]  = '{0,  0,  0,  12, 0,  0, 12,  0,  12,  1,  0,  2'b00, 2'b10, 0,  0,  0,  0};
    vecs[5]  = '{0,  3,  0,  0,  3,  1, 0,   0,  0,   0,  0,  2'b00, 2'b00, 1,  1,  1,  0};
    vecs[6]  = '{4,  0,  0,  0,  4,  1, 0,   0,  0,   0,  0,  2'b00, 2'b00, 1,  1,  1,  0};
    vecs[7]  = '{0,  0,  0,  0,  0,  1, 0,   0,  0,   0,  0,  2'b00, 2'b00, 0,  0,  0,  0};
    vecs[8]  = '{6,  0,  0,  0,  6,  0, 0,   0,  0,   0,  0,  2'b00, 2'b00, 0,  0,  0,  0};
    vecs[9]  = '{0,  3,  0,  0,  3,  1, 0,   0,  0,   0,  1,  2'b00, 2'b00, 0,  0,  1,  1};
    vecs[10] = '{0,  0,  0,  0,  0,  0, 0,   0,  0,   0,  1,  2'b00, 2'b00, 0,  0,  1,  1};
    vecs[11] = '{8,  2,  2,  0,  2,  1, 2,   1,  0,   0,  0,  2'b01, 2'b00, 1,  1,  1,  0};

    // Reset state, with inputs that would otherwise forward and load-use stall
    clear_inputs();
    rst = 1'b1;
    ide_rs1 = 5; exm_rd = 5; exm_wr = 1'b1;
    mem_read = 1'b1; ide_rd = 3; id_rs2 = 3;
    #1;
    chk("rst_fwd_a", ifc.forward_a_sel_o, 2'b00);
    chk("rst_pc_stall", ifc.pc_stall_o, 0);
    chk("rst_bubble", ifc.id_ex_bubble_o, 0);
    chk("rst_stall_cnt", ifc.stall_cycles_o, 0);
    chk("rst_flush_cnt", ifc.flush_count_o, 0);
    chk("rst_timeout", ifc.div_timeout_o, 0);
    #20 rst = 1'b0;
    clear_inputs();

    // Combinational vector table (state stays RUN)
    for (int i = 0; i < 12; i++) begin
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
      ide_rs1 = vecs[i].ide_rs1; ide_rs2 = vecs[i].ide_rs2; ide_rd = vecs[i].ide_rd;
      mem_read = vecs[i].mem_read; exm_rd = vecs[i].exm_rd; exm_wr = vecs[i].exm_wr;
      mwb_rd = vecs[i].mwb_rd; mwb_wr = vecs[i].mwb_wr; branch = vecs[i].branch;
      #1;
      chk($sformatf("v%0d_fwd_a", i), ifc.forward_a_sel_o, vecs[i].fa);
      chk($sformatf("v%0d_fwd_b", i), ifc.forward_b_sel_o, vecs[i].fb);
      chk($sformatf("v%0d_pc_stall", i), ifc.pc_stall_o, vecs[i].pcs);
      chk($sformatf("v%0d_if_id_stall", i), ifc.if_id_stall_o, vecs[i].ifs);
      chk($sformatf("v%0d_id_ex_stall", i), ifc.id_ex_stall_o, 0);
      chk($sformatf("v%0d_bubble", i), ifc.id_ex_bubble_o, vecs[i].bub);
      chk($sformatf("v%0d_flush", i), ifc.if_id_flush_o, vecs[i].fl);
    end

    // Load-use: one stalled cycle, bubble clears the load
    do_reset();
    edge1();
    mem_read = 1'b1; ide_rd = 3; id_rs2 = 3;
    @(negedge clk);
    chk("lu_pc_stall", ifc.pc_stall_o, 1);
    chk("lu_bubble", ifc.id_ex_bubble_o, 1);
    edge1();
    mem_read = 1'b0;
    @(negedge clk);
    chk("lu_pc_stall_after", ifc.pc_stall_o, 0);
    chk("lu_stall_cnt", ifc.stall_cycles_o, 1);

    // Branch beats load-use
    do_reset();
    edge1();
    mem_read = 1'b1; ide_rd = 3; id_rs2 = 3; branch = 1'b1;
    @(negedge clk);
    chk("br_flush", ifc.if_id_flush_o, 1);
    chk("br_bubble", ifc.id_ex_bubble_o, 1);
    chk("br_pc_stall", ifc.pc_stall_o, 0);
    chk("br_if_id_stall", ifc.if_id_stall_o, 0);
    edge1();
    clear_inputs();
    @(negedge clk);
    chk("br_flush_cnt", ifc.flush_count_o, 1);
    chk("br_stall_cnt", ifc.stall_cycles_o, 0);

    // 10-cycle divide
    do_reset();
    edge1();
    div_start = 1'b1;
    @(negedge clk);
    chk("div_start_no_stall", ifc.pc_stall_o, 0);
    edge1();
    div_start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.pc_stall_o && ifc.if_id_stall_o && ifc.id_ex_stall_o) n++;
      edge1();
    end
    chk("div_stalled_cycles", n, 10);
    div_done = 1'b1;
    @(negedge clk);
    chk("div_done_same_cycle", ifc.pc_stall_o, 0);
    chk("div_done_id_ex", ifc.id_ex_stall_o, 0);
    edge1();
    div_done = 1'b0;
    @(negedge clk);
    chk("div_back_run", ifc.pc_stall_o, 0);
    chk("div_stall_cnt", ifc.stall_cycles_o, 10);

    // Single-cycle divide
    edge1();
    div_start = 1'b1; div_done = 1'b1;
    @(negedge clk);
    chk("div1_no_stall", ifc.pc_stall_o, 0);
    edge1();
    div_start = 1'b0; div_done = 1'b0;
    @(negedge clk);
    chk("div1_still_run", ifc.pc_stall_o, 0);
    chk("div1_stall_cnt", ifc.stall_cycles_o, 10);

    // Watchdog on the DIV_TIMEOUT=8 instance
    do_reset();
    edge1();
    div_start = 1'b1;
    edge1();
    div_start = 1'b0;
    @(negedge clk);
    chk("wd_flag_early", ifc_wd.div_timeout_o, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ifc_wd.pc_stall_o) break;
      n++;
      @(negedge clk);
    end
    chk("wd_stalled_cycles", n, 8);
    chk("wd_flag_set", ifc_wd.div_timeout_o, 1);
    repeat (3) @(negedge clk);
    chk("wd_flag_sticky", ifc_wd.div_timeout_o, 1);
    chk("wd_run_no_stall", ifc_wd.pc_stall_o, 0);
    do_reset();
    chk("wd_flag_cleared", ifc_wd.div_timeout_o, 0);

    // Async reset in the middle of DIV_WAIT
    do_reset();
    ide_rs1 = 5; exm_rd = 5; exm_wr = 1'b1;
    edge1();
    div_start = 1'b1;
    edge1();
    div_start = 1'b0;
    repeat (2) edge1();
    @(negedge clk);
    chk("ar_stalling", ifc.pc_stall_o, 1);
    chk("ar_fwd_pre", ifc.forward_a_sel_o, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("ar_pc_stall", ifc.pc_stall_o, 0);
    chk("ar_id_ex_stall", ifc.id_ex_stall_o, 0);
    chk("ar_stall_cnt", ifc.stall_cycles_o, 0);
    chk("ar_fwd_a", ifc.forward_a_sel_o, 2'b00);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ar_run_no_stall", ifc.pc_stall_o, 0);
    chk("ar_fwd_post", ifc.forward_a_sel_o, 2'b01);
    edge1();
    mem_read = 1'b1; ide_rd = 4; id_rs1 = 4;
    @(negedge clk);
    chk("ar_run_load_use", ifc.id_ex_bubble_o, 1);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Control-side counterpart of the EX stage datapath in the RV32IM five-stage pipeline.
- Generates the forward_a/forward_b operand-select codes that the EX stage consumes.
- Owns pipeline stall and flush control for three cases: load-use hazards, multi-cycle divide occupancy and taken branches/jumps.
- Keeps a small run/divide-wait state machine, a divide watchdog and saturating performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of each performance counter.
- DIV_TIMEOUT, 64, maximum cycles in DIV_WAIT before the watchdog fires.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1_addr_i / id_rs2_addr_i  in  REG_AW each  source registers of the instruction in IF/ID.
- id_ex_rs1_addr_i / id_ex_rs2_addr_i  in  REG_AW each  source registers held in ID/EX.
- id_ex_rd_addr_i  in  REG_AW  destination held in ID/EX.
- id_ex_mem_read_i  in  1  ID/EX instruction is a load.
- ex_mem_rd_addr_i  in  REG_AW  destination held in EX/MEM.
- ex_mem_reg_write_i  in  1  EX/MEM will write rd.
- mem_wb_rd_addr_i  in  REG_AW  destination held in MEM/WB.
- mem_wb_reg_write_i  in  1  MEM/WB will write rd.
- div_start_i  in  1  EX launches a DIV/REM this cycle.
- div_done_i  in  1  divider result is valid this cycle.
- branch_taken_i  in  1  EX resolved a taken branch, JAL or JALR.
- forward_a_sel_o / forward_b_sel_o  out  2 each  00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- id_ex_stall_o  out  1  hold ID/EX.
- id_ex_bubble_o  out  1  load a NOP into ID/EX.
- if_id_flush_o  out  1  clear IF/ID.
- div_timeout_o  out  1  sticky watchdog error flag.
- stall_cycles_o  out  CNT_W  count of stalled cycles.
- flush_count_o  out  CNT_W  count of flush events.

Behaviour:
- Reset (asynchronous, while rst = 1):
  - state = RUN; watchdog counter, stall_cycles_o, flush_count_o and div_timeout_o = 0.
  - All combinational control outputs are forced to 0, and forward selects to 00.
- Forwarding (combinational, zero latency), operand A:
  - 01 if ex_mem_reg_write_i, ex_mem_rd_addr_i != 0 and ex_mem_rd_addr_i == id_ex_rs1_addr_i.
  - Otherwise 10 if the same three conditions hold for the MEM/WB stage.
  - Otherwise 00.
  - EX/MEM has priority when both stages match. x0 never forwards. Code 11 is never driven.
  - Operand B uses the same rules on id_ex_rs2_addr_i.
- Load-use (combinational), active in RUN only:
  - Fires when id_ex_mem_read_i, id_ex_rd_addr_i != 0 and id_ex_rd_addr_i matches id_rs1_addr_i or id_rs2_addr_i.
  - Response: pc_stall_o = 1, if_id_stall_o = 1, id_ex_bubble_o = 1 for exactly that cycle.
  - The bubble clears id_ex_mem_read_i on the next cycle, so the stall is self-terminating.
- FSM states are RUN and DIV_WAIT.
- RUN transitions:
  - div_start_i = 1 and div_done_i = 0 → DIV_WAIT, with the watchdog counter cleared to 0.
  - div_start_i and div_done_i both 1 (single-cycle divide) → stay in RUN, no stall.
- DIV_WAIT behaviour:
  - pc_stall_o, if_id_stall_o and id_ex_stall_o = 1 every cycle that div_done_i = 0.
  - On div_done_i = 1: stall outputs deassert in that same cycle, and the state → RUN next edge.
  - Load-use detection is masked in this state.
  - The watchdog increments each cycle. On reaching DIV_TIMEOUT−1 it sets div_timeout_o (sticky until reset) and forces → RUN.
- Branch flush, when branch_taken_i = 1:
  - if_id_flush_o = 1 and id_ex_bubble_o = 1 in the same cycle.
  - Overrides load-use: pc_stall_o and if_id_stall_o are forced to 0 so the new target is fetched.
  - branch_taken_i cannot occur in DIV_WAIT, because EX is held. If it does, the flush still wins and the state stays DIV_WAIT.
- Counters (saturate at all-ones, never wrap):
  - stall_cycles_o increments on every cycle with pc_stall_o = 1.
  - flush_count_o increments on every cycle with if_id_flush_o = 1.
- Simultaneous div_start_i and load-use in RUN: load-use outputs are asserted this cycle and the FSM still enters DIV_WAIT.

Decomposition:
- Shared package (pipeline_pkg):
  - Forward-select constants FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - FSM state encoding.
  - REG_AW default.
- One natural sub-module, fwd_select: the pure combinational match/priority logic for one operand, instantiated twice (A and B).
- FSM, watchdog and counters stay in the top module.

Test Plan:
- Fwd priority: id_ex_rs1 = 5, EX/MEM rd = 5 wr = 1, MEM/WB rd = 5 wr = 1 → forward_a_sel_o = 01. Clear EX/MEM write → 10. Set all rd = 0 → 00.
- Load-use: id_ex_mem_read = 1, id_ex_rd = 3, id_rs2 = 3 → pc_stall, if_id_stall and id_ex_bubble = 1 for exactly one cycle; stall_cycles_o increments by 1.
- Divide: div_start pulse, div_done after 10 cycles → 10 stalled cycles, then RUN. A start with same-cycle div_done → 0 stall cycles.
- Watchdog: DIV_TIMEOUT = 8, div_done never asserted → div_timeout_o = 1 after 8 cycles in DIV_WAIT, state returns to RUN, flag persists until rst.
- Branch vs load-use: load-use condition and branch_taken_i in the same cycle → if_id_flush = 1, id_ex_bubble = 1, pc_stall = 0; flush_count_o = 1.
- Async reset mid-DIV_WAIT: assert rst between edges → stalls drop immediately, counters read 0, and after release state is RUN.
